// File: rtl/accelerator_pkg.sv
// Shared types and constants for the vector load/store unit.
// The FSM state type and the tail byte-enable helper live here so the top and the address generator agree.
package accelerator_pkg;

    localparam int VLSU_ELEMS_PER_WORD = 4;
    localparam int VLSU_MAX_VL         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } vlsu_state_t;

    // Byte enables for a partially filled final word holding rem elements.
    function automatic logic [3:0] vlsu_tail_be(input logic [1:0] rem);
        logic [3:0] be;
        case (rem)
            2'd1:    be = 4'b0001;
            2'd2:    be = 4'b0011;
            2'd3:    be = 4'b0111;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/vlsu_addr_gen.sv
// Element/word counter and running address accumulator for the vector LSU.
// Presents the current bus address, byte enable, byte lane and a last-transaction flag.
module vlsu_addr_gen
    import accelerator_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              byte_mode_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] step_bytes_i,
    input  logic [4:0]        vl_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [3:0]        be_o,
    output logic [1:0]        lane_o,
    output logic [3:0]        elem_o,
    output logic              byte_mode_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [4:0]        vl_q, vl_d;
    logic              byte_mode_q, byte_mode_d;
    logic [5:0]        cnt_inc;

    // Byte mode moves one element per transaction, word mode a whole word of elements.
    assign cnt_inc = byte_mode_q ? 6'd1 : 6'(VLSU_ELEMS_PER_WORD);

    always_comb begin
        addr_d      = addr_q;
        stride_d    = stride_q;
        cnt_d       = cnt_q;
        vl_d        = vl_q;
        byte_mode_d = byte_mode_q;
        if (start_i) begin
            addr_d      = base_i;
            stride_d    = step_bytes_i;
            cnt_d       = 5'd0;
            vl_d        = vl_i;
            byte_mode_d = byte_mode_i;
        end else if (step_i) begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_q + cnt_inc[4:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            stride_q    <= '0;
            cnt_q       <= '0;
            vl_q        <= '0;
            byte_mode_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            cnt_q       <= cnt_d;
            vl_q        <= vl_d;
            byte_mode_q <= byte_mode_d;
        end
    end

    assign last_o      = ({1'b0, cnt_q} + cnt_inc) >= {1'b0, vl_q};
    assign addr_o      = {addr_q[ADDR_W-1:2], 2'b00};
    assign lane_o      = addr_q[1:0];
    assign elem_o      = cnt_q[3:0];
    assign byte_mode_o = byte_mode_q;

    always_comb begin
        if (byte_mode_q) begin
            be_o = 4'b0001 << addr_q[1:0];
        end else if (last_o) begin
            be_o = vlsu_tail_be(vl_q[1:0]);
        end else begin
            be_o = 4'b1111;
        end
    end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves up to 16 byte elements between a 128-bit group buffer and the data bus.
// One outstanding bus transaction at a time; word accesses for aligned unit stride, byte accesses otherwise.
module vector_lsu
    import accelerator_pkg::*;
#(
    parameter int MAX_VL = VLSU_MAX_VL,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic              strided_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [4:0]        vl_i,
    input  logic [127:0]      store_data_i,
    output logic              ready_o,
    output logic [127:0]      load_data_o,
    output logic              load_valid_o,
    output logic              store_done_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [31:0]       data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [31:0]       data_rdata_i
);

    vlsu_state_t       state_q;
    logic              ready_q, req_q, load_valid_q, store_done_q, op_load_q;
    logic [127:0]      store_data_q;
    logic [127:0]      load_buf_q, load_buf_d;

    logic              accept, step, byte_mode_in;
    logic [ADDR_W-1:0] step_bytes;
    logic [4:0]        vl_clamped;

    logic [ADDR_W-1:0] ag_addr;
    logic [3:0]        ag_be;
    logic [1:0]        ag_lane;
    logic [3:0]        ag_elem;
    logic              ag_byte_mode, ag_last;

    logic [31:0]       word_sel, be_mask, wdata_raw;
    logic [7:0]        byte_sel, rdata_lane;

    assign vl_clamped   = (vl_i > 5'(MAX_VL)) ? 5'(MAX_VL) : vl_i;
    // A misaligned unit-stride access falls back to byte accesses with stride 1.
    assign byte_mode_in = strided_i | (base_addr_i[1:0] != 2'b00);
    assign step_bytes   = strided_i    ? stride_i :
                          byte_mode_in ? ADDR_W'(1) : ADDR_W'(VLSU_ELEMS_PER_WORD);
    assign accept       = (state_q == IDLE) & en_i & (load_i ^ store_i);
    assign step         = (state_q == RESP) & data_rvalid_i;

    vlsu_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk          (clk),
        .reset        (reset),
        .start_i      (accept),
        .byte_mode_i  (byte_mode_in),
        .base_i       (base_addr_i),
        .step_bytes_i (step_bytes),
        .vl_i         (vl_clamped),
        .step_i       (step),
        .addr_o       (ag_addr),
        .be_o         (ag_be),
        .lane_o       (ag_lane),
        .elem_o       (ag_elem),
        .byte_mode_o  (ag_byte_mode),
        .last_o       (ag_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            req_q        <= 1'b0;
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            op_load_q    <= 1'b0;
            store_data_q <= '0;
        end else begin
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ready_q      <= 1'b0;
                        op_load_q    <= load_i;
                        store_data_q <= store_data_i;
                        if (vl_clamped == 5'd0) begin
                            state_q      <= DONE;
                            load_valid_q <= load_i;
                            store_done_q <= store_i;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (data_rvalid_i) begin
                        if (ag_last) begin
                            state_q      <= DONE;
                            load_valid_q <= op_load_q;
                            store_done_q <= ~op_load_q;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Per-byte buffer update: in word mode the four lanes map onto the current word's elements.
    assign rdata_lane = data_rdata_i[{ag_lane, 3'b000} +: 8];

    for (genvar gi = 0; gi < 16; gi++) begin : g_buf
        localparam int LANE = gi % VLSU_ELEMS_PER_WORD;
        logic hit;
        assign hit = ag_byte_mode ? (ag_elem == 4'(gi))
                                  : ((ag_elem[3:2] == 2'(gi / VLSU_ELEMS_PER_WORD)) && ag_be[LANE]);
        assign load_buf_d[8*gi +: 8] = (step && op_load_q && hit)
                                     ? (ag_byte_mode ? rdata_lane : data_rdata_i[8*LANE +: 8])
                                     : load_buf_q[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_buf_q <= '0;
        end else if (accept && load_i) begin
            load_buf_q <= '0;
        end else begin
            load_buf_q <= load_buf_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        assign be_mask[8*gi +: 8] = {8{ag_be[gi]}};
    end

    assign word_sel  = store_data_q[{ag_elem[3:2], 5'b00000} +: 32];
    assign byte_sel  = store_data_q[{ag_elem, 3'b000} +: 8];
    assign wdata_raw = ag_byte_mode ? (32'(byte_sel) << {ag_lane, 3'b000}) : (word_sel & be_mask);

    // Bus fields come from registered state only, so they hold steady across grant stalls.
    assign data_req_o   = req_q;
    assign data_addr_o  = req_q ? ag_addr : '0;
    assign data_we_o    = req_q & ~op_load_q;
    assign data_be_o    = req_q ? ag_be : 4'b0000;
    assign data_wdata_o = (req_q && !op_load_q) ? wdata_raw : 32'd0;

    assign ready_o      = ready_q;
    assign load_valid_o = load_valid_q;
    assign store_done_o = store_done_q;
    assign load_data_o  = load_buf_q;

endmodule
